// File: rtl/mem_page_request_scheduler.sv
// Page-command sequencer for the main-memory final request queue.
// Keeps a single bank/page open while the head of the queue keeps hitting it,
// uses the two peek entries to precharge as soon as a miss is known, and closes
// an idle page after OPEN_TIMEOUT empty cycles. RD/WR pops the queue head on
// the same cycle the memory accepts the command.
module mem_page_request_scheduler #(
  parameter int BANK_W         = 2,
  parameter int PAGE_W         = 12,
  parameter int WORD_W         = 8,
  parameter int REQ_DATA_WIDTH = 1 + BANK_W + PAGE_W + WORD_W,
  parameter int T_RCD          = 3,
  parameter int T_RP           = 3,
  parameter int OPEN_TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic                      clear,
  input  logic                      pipe_valid,
  input  logic [REQ_DATA_WIDTH-1:0] pipe_data,
  input  logic                      pipe_peek_valid,
  input  logic [REQ_DATA_WIDTH-1:0] pipe_peek_data,
  input  logic                      pipe_peek_twoIn_valid,
  input  logic [REQ_DATA_WIDTH-1:0] pipe_peek_twoIn_data,
  output logic                      pipe_read,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [1:0]                cmd_op,
  output logic [BANK_W-1:0]         cmd_bank,
  output logic [PAGE_W-1:0]         cmd_page,
  output logic [WORD_W-1:0]         cmd_word,
  output logic [1:0]                cmd_hint,
  output logic                      page_open
);

  localparam int LOC_W  = BANK_W + PAGE_W;
  localparam int T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX  = (T_MAX0 > OPEN_TIMEOUT) ? T_MAX0 : OPEN_TIMEOUT;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] RCD_LOAD  = TW'(T_RCD);
  localparam logic [TW-1:0] RP_LOAD   = TW'(T_RP);
  localparam logic [TW-1:0] IDLE_LIM  = TW'(OPEN_TIMEOUT);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  localparam logic [1:0] OP_ACT = 2'b00;
  localparam logic [1:0] OP_PRE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_TRCD,
    S_ACCESS,
    S_PRE,
    S_TRP
  } state_t;

  state_t            state_q, state_d;
  logic              page_open_q, page_open_d;
  logic [BANK_W-1:0] open_bank_q, open_bank_d;
  logic [PAGE_W-1:0] open_page_q, open_page_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [TW-1:0]     idle_q, idle_d;

  logic [LOC_W-1:0]  head_loc, peek_loc, two_loc, open_loc;
  logic              head_op;
  logic [WORD_W-1:0] head_word;
  logic              head_hit, peek_hit, two_hit;
  logic              hint_one, hint_two;
  logic              offer_rdwr, kill, accept;
  logic              unused_peek_fields;

  // Timers never wrap: increment and decrement both stick at their limits.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + TMR_ONE;
  endfunction

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TMR_ONE;
  endfunction

  // Only {bank, page} matter for page matching; op and word of the peek
  // entries are never looked at.
  assign head_loc  = pipe_data[WORD_W +: LOC_W];
  assign head_op   = pipe_data[REQ_DATA_WIDTH-1];
  assign head_word = pipe_data[WORD_W-1:0];
  assign peek_loc  = pipe_peek_data[WORD_W +: LOC_W];
  assign two_loc   = pipe_peek_twoIn_data[WORD_W +: LOC_W];
  assign open_loc  = {open_bank_q, open_page_q};
  assign unused_peek_fields = ^{pipe_peek_data[REQ_DATA_WIDTH-1], pipe_peek_data[WORD_W-1:0],
                                pipe_peek_twoIn_data[REQ_DATA_WIDTH-1],
                                pipe_peek_twoIn_data[WORD_W-1:0]};

  assign head_hit = page_open_q && (head_loc == open_loc);
  assign peek_hit = page_open_q && (peek_loc == open_loc);
  assign two_hit  = page_open_q && (two_loc == open_loc);
  assign hint_one = pipe_peek_valid && peek_hit;
  assign hint_two = hint_one && pipe_peek_twoIn_valid && two_hit;

  assign page_open = page_open_q;

  // Command offer and handshake; reset/clear withdraw the offer at once so
  // nothing is issued or popped on a flush cycle.
  always_comb begin
    offer_rdwr = (state_q == S_ACCESS) && pipe_valid && head_hit;
    kill       = reset_poweron || clear;
    cmd_valid  = ((state_q == S_ACT) || (state_q == S_PRE) || offer_rdwr) && !kill;
    accept     = cmd_valid && cmd_ready;
    pipe_read  = accept && offer_rdwr;
    cmd_op     = OP_ACT;
    cmd_bank   = '0;
    cmd_page   = '0;
    cmd_word   = '0;
    cmd_hint   = '0;
    case (state_q)
      S_ACT: begin
        cmd_op               = OP_ACT;
        {cmd_bank, cmd_page} = head_loc;
      end
      S_PRE: begin
        cmd_op               = OP_PRE;
        {cmd_bank, cmd_page} = open_loc;
      end
      S_ACCESS: begin
        if (offer_rdwr) begin
          cmd_op               = {1'b1, head_op};
          {cmd_bank, cmd_page} = open_loc;
          cmd_word             = head_word;
          cmd_hint             = {1'b0, hint_one} + {1'b0, hint_two};
        end
      end
      default: ;
    endcase
  end

  // Next-state: page lifecycle ACT -> tRCD -> accesses -> PRE -> tRP.
  always_comb begin
    state_d     = state_q;
    page_open_d = page_open_q;
    open_bank_d = open_bank_q;
    open_page_d = open_page_q;
    wait_d      = wait_q;
    idle_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (pipe_valid) state_d = S_ACT;
      end
      S_ACT: begin
        if (accept) begin
          {open_bank_d, open_page_d} = head_loc;
          page_open_d = 1'b1;
          wait_d      = RCD_LOAD;
          state_d     = S_TRCD;
        end
      end
      S_TRCD: begin
        if (wait_q <= TMR_ONE) state_d = S_ACCESS;
        else                   wait_d  = sat_dec(wait_q);
      end
      S_ACCESS: begin
        if (pipe_valid) begin
          if (!head_hit) begin
            state_d = S_PRE;
          end else if (accept && pipe_peek_valid && !peek_hit) begin
            // The next request is already known to miss: close right away.
            state_d = S_PRE;
          end
        end else begin
          idle_d = sat_inc(idle_q);
          if (idle_d >= IDLE_LIM) state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (accept) begin
          page_open_d = 1'b0;
          wait_d      = RP_LOAD;
          state_d     = S_TRP;
        end
      end
      S_TRP: begin
        if (wait_q <= TMR_ONE) state_d = pipe_valid ? S_ACT : S_IDLE;
        else                   wait_d  = sat_dec(wait_q);
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      page_open_d = 1'b0;
      open_bank_d = '0;
      open_page_d = '0;
      wait_d      = '0;
      idle_d      = '0;
    end
  end

  // State registers with synchronous power-on reset.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q     <= S_IDLE;
      page_open_q <= 1'b0;
      open_bank_q <= '0;
      open_page_q <= '0;
      wait_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      page_open_q <= page_open_d;
      open_bank_q <= open_bank_d;
      open_page_q <= open_page_d;
      wait_q      <= wait_d;
      idle_q      <= idle_d;
    end
  end

endmodule

// File: tb/tb_mem_page_request_scheduler.sv
// Bench for mem_page_request_scheduler: a queue-backed request source, a
// timestamp-based page model checked every cycle, a pop-order scoreboard and
// literal expectations for the directed scenarios.
module tb_mem_page_request_scheduler;
  localparam int BANK_W = 2, PAGE_W = 12, WORD_W = 8;
  localparam int REQ = 1 + BANK_W + PAGE_W + WORD_W;
  localparam int T_RCD = 3, T_RP = 3, OPEN_TIMEOUT = 16;

  typedef logic [REQ-1:0] req_t;

  logic              clk, reset_poweron, clear;
  logic              pipe_valid, pipe_peek_valid, pipe_peek_twoIn_valid;
  req_t              pipe_data, pipe_peek_data, pipe_peek_twoIn_data;
  logic              pipe_read, cmd_valid, cmd_ready;
  logic [1:0]        cmd_op, cmd_hint;
  logic [BANK_W-1:0] cmd_bank;
  logic [PAGE_W-1:0] cmd_page;
  logic [WORD_W-1:0] cmd_word;
  logic              page_open;

  mem_page_request_scheduler #(
    .BANK_W(BANK_W), .PAGE_W(PAGE_W), .WORD_W(WORD_W), .REQ_DATA_WIDTH(REQ),
    .T_RCD(T_RCD), .T_RP(T_RP), .OPEN_TIMEOUT(OPEN_TIMEOUT)
  ) dut (
    .clk(clk), .reset_poweron(reset_poweron), .clear(clear),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .pipe_peek_valid(pipe_peek_valid), .pipe_peek_data(pipe_peek_data),
    .pipe_peek_twoIn_valid(pipe_peek_twoIn_valid), .pipe_peek_twoIn_data(pipe_peek_twoIn_data),
    .pipe_read(pipe_read), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_page(cmd_page), .cmd_word(cmd_word),
    .cmd_hint(cmd_hint), .page_open(page_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  req_t q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   pops = 0, pushed = 0, rdwr_cnt = 0;
  int   lg_op[$], lg_cyc[$], lg_hint[$], lg_page[$];

  // Model: page state plus the cycle numbers at which things become legal.
  bit                m_open, m_pre, m_act;
  logic [BANK_W-1:0] m_ob;
  logic [PAGE_W-1:0] m_opg;
  int                m_busy, m_decide, m_idle;

  function automatic logic [BANK_W-1:0] f_bank(input req_t r);
    return r[WORD_W+PAGE_W +: BANK_W];
  endfunction
  function automatic logic [PAGE_W-1:0] f_page(input req_t r);
    return r[WORD_W +: PAGE_W];
  endfunction
  function automatic logic [WORD_W-1:0] f_word(input req_t r);
    return r[WORD_W-1:0];
  endfunction
  function automatic req_t mk(input bit op, input int bank, input int page, input int word);
    return {op, BANK_W'(bank), PAGE_W'(page), WORD_W'(word)};
  endfunction
  function automatic bit m_hit(input req_t r);
    return m_open && (f_bank(r) == m_ob) && (f_page(r) == m_opg);
  endfunction

  function automatic int lop(input int i);  return (i < lg_op.size())   ? lg_op[i]   : -1; endfunction
  function automatic int lcy(input int i);  return (i < lg_cyc.size())  ? lg_cyc[i]  : -1; endfunction
  function automatic int lhi(input int i);  return (i < lg_hint.size()) ? lg_hint[i] : -1; endfunction
  function automatic int lpg(input int i);  return (i < lg_page.size()) ? lg_page[i] : -1; endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input bit op, input int bank, input int page, input int word);
    q.push_back(mk(op, bank, page, word));
    pushed++;
  endtask

  task automatic drive_pipe();
    pipe_valid            = (q.size() > 0);
    pipe_data             = (q.size() > 0) ? q[0] : '0;
    pipe_peek_valid       = (q.size() > 1);
    pipe_peek_data        = (q.size() > 1) ? q[1] : '0;
    pipe_peek_twoIn_valid = (q.size() > 2);
    pipe_peek_twoIn_data  = (q.size() > 2) ? q[2] : '0;
  endtask

  // One clock cycle: apply inputs, compare against the model, advance.
  task automatic step(input bit rdy, input bit clr, input bit rst);
    bit                kill, e_valid, e_read, do_pop;
    logic [1:0]        e_op, e_hint;
    logic [BANK_W-1:0] e_bank;
    logic [PAGE_W-1:0] e_page;
    logic [WORD_W-1:0] e_word;
    cmd_ready = rdy; clear = clr; reset_poweron = rst;
    drive_pipe();
    #1;
    kill = clr | rst;
    e_valid = 0; e_op = 0; e_bank = 0; e_page = 0; e_word = 0; e_hint = 0;
    if (!m_open) begin
      if (m_act && q.size() > 0) begin
        e_valid = 1; e_op = 2'b00; e_bank = f_bank(q[0]); e_page = f_page(q[0]);
      end
    end else if (m_pre) begin
      e_valid = 1; e_op = 2'b01; e_bank = m_ob; e_page = m_opg;
    end else if (cyc >= m_busy && q.size() > 0 && m_hit(q[0])) begin
      e_valid = 1; e_op = {1'b1, q[0][REQ-1]}; e_bank = m_ob; e_page = m_opg;
      e_word = f_word(q[0]);
      if (q.size() > 1 && m_hit(q[1])) begin
        e_hint = 2'd1;
        if (q.size() > 2 && m_hit(q[2])) e_hint = 2'd2;
      end
    end
    if (kill) e_valid = 0;
    e_read = e_valid && rdy && e_op[1];

    chk("page_open", page_open, m_open);
    chk("cmd_valid", cmd_valid, e_valid);
    chk("pipe_read", pipe_read, e_read);
    if (e_valid)
      chk("cmd_fields", {cmd_op, cmd_bank, cmd_page, cmd_word, cmd_hint},
          {e_op, e_bank, e_page, e_word, e_hint});

    if (cmd_valid && cmd_ready) begin
      lg_op.push_back(int'(cmd_op)); lg_cyc.push_back(cyc);
      lg_hint.push_back(int'(cmd_hint)); lg_page.push_back(int'(cmd_page));
      if (cmd_op[1]) rdwr_cnt++;
    end
    do_pop = 0;
    if (pipe_read) begin
      pops++;
      if (q.size() > 0) begin
        chk("sb_pop", {cmd_valid & cmd_ready, cmd_op, cmd_bank, cmd_page, cmd_word},
            {1'b1, 1'b1, q[0][REQ-1], f_bank(q[0]), f_page(q[0]), f_word(q[0])});
        do_pop = 1;
      end else begin
        chk("pop_empty", q.size(), 1);
      end
    end

    if (kill) begin
      m_open = 0; m_pre = 0; m_act = 0; m_ob = '0; m_opg = '0;
      m_idle = 0; m_busy = 0; m_decide = cyc + 1;
    end else if (!m_open) begin
      if (m_act) begin
        if (rdy && q.size() > 0) begin
          m_open = 1; m_act = 0; m_ob = f_bank(q[0]); m_opg = f_page(q[0]);
          m_busy = cyc + 1 + T_RCD; m_idle = 0;
        end
      end else if (cyc >= m_decide && q.size() > 0) begin
        m_act = 1;
      end
    end else if (m_pre) begin
      if (rdy) begin m_open = 0; m_pre = 0; m_decide = cyc + T_RP; end
    end else if (cyc >= m_busy) begin
      if (q.size() > 0) begin
        m_idle = 0;
        if (m_hit(q[0])) begin
          if (rdy && q.size() > 1 && !m_hit(q[1])) m_pre = 1;
        end else begin
          m_pre = 1;
        end
      end else begin
        m_idle++;
        if (m_idle >= OPEN_TIMEOUT) m_pre = 1;
      end
    end

    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    cyc++;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 1'b0);
  endtask

  task automatic begin_test();
    q.delete();
    lg_op.delete(); lg_cyc.delete(); lg_hint.delete(); lg_page.delete();
    pops = 0; pushed = 0; rdwr_cnt = 0;
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_poweron = 1'b1; clear = 1'b0; cmd_ready = 1'b0;
    m_open = 0; m_pre = 0; m_act = 0; m_ob = '0; m_opg = '0;
    m_busy = 0; m_decide = 0; m_idle = 0;
    drive_pipe();
    repeat (2) @(posedge clk);
    #1;

    // 1: four reads to one page, hints, then idle close
    begin_test();
    chk("t1_reset_open", page_open, 0);
    for (int w = 0; w < 4; w++) push(1'b0, 1, 'h010, w);
    run(30, 1'b1);
    chk("t1_nlog", lg_op.size(), 6);
    chk("t1_act", lop(0), 0);
    chk("t1_act_page", lpg(0), 'h010);
    chk("t1_trcd_gap", lcy(1) - lcy(0), 4);
    chk("t1_hint0", lhi(1), 2);
    chk("t1_hint1", lhi(2), 2);
    chk("t1_hint2", lhi(3), 1);
    chk("t1_hint3", lhi(4), 0);
    chk("t1_b2b", lcy(4) - lcy(1), 3);
    chk("t1_pre", lop(5), 1);
    chk("t1_timeout", lcy(5) - lcy(4), 17);

    // 2: page miss precharges right after the read
    begin_test();
    push(1'b0, 1, 'h010, 5);
    push(1'b1, 1, 'h020, 6);
    run(30, 1'b1);
    chk("t2_ops", {lop(0), lop(1), lop(2), lop(3), lop(4)}, {32'd0, 32'd2, 32'd1, 32'd0, 32'd3});
    chk("t2_rd_gap", lcy(1) - lcy(0), 4);
    chk("t2_pre_gap", lcy(2) - lcy(1), 1);
    chk("t2_trp_gap", lcy(3) - lcy(2), 4);
    chk("t2_wr_gap", lcy(4) - lcy(3), 4);
    chk("t2_act2_page", lpg(3), 'h020);

    // 3: back-pressure during ACT and during RD
    begin_test();
    push(1'b0, 2, 'h033, 7);
    run(6, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run(8, 1'b0);
    chk("t3_no_pop_yet", pops, 0);
    step(1'b1, 1'b0, 1'b0);
    run(2, 1'b0);
    chk("t3_pops", pops, 1);
    chk("t3_nlog", lg_op.size(), 2);
    chk("t3_rd_after_act", lcy(1) - lcy(0), 9);

    // 4: new hit just before timeout keeps the page open
    begin_test();
    push(1'b0, 0, 'h005, 1);
    run(6, 1'b1);
    run(15, 1'b1);
    push(1'b0, 0, 'h005, 2);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_rd2", lop(2), 2);
    chk("t4_rd_gap", lcy(2) - lcy(1), 16);
    run(16, 1'b1);
    chk("t4_no_pre", lg_op.size(), 3);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_pre", lop(3), 1);

    // 5: clear in tRCD and clear against an accepted RD
    begin_test();
    push(1'b1, 3, 'h0ab, 9);
    run(2, 1'b1);
    chk("t5_open_before", page_open, 1);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_clr_trcd", page_open, 0);
    run(5, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_clr_access", page_open, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_no_pop", pops, 0);

    // 6: reset mid-burst, then random traffic with pop-order scoreboard
    begin_test();
    for (int w = 0; w < 3; w++) push(1'b0, 3, 'h100, w);
    run(6, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("t6_rst_open", page_open, 0);
    chk("t6_pops", pops, 1);
    q.delete();
    pushed = 0; rdwr_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (q.size() < 3 && $urandom_range(0, 2) == 0)
        push(1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 2),
             $urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 1'b0);
    end
    for (int i = 0; i < 400 && q.size() > 0; i++) step(1'b1, 1'b0, 1'b0);
    chk("t6_drain_empty", q.size(), 0);
    chk("t6_drain_count", rdwr_cnt, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
